// File: rtl/flo_pkg.sv
// rtl/flo_pkg.sv - shared mode type, index-width helper and no-hit marker for flo_pipe
package flo_pkg;

  typedef enum logic {
    FLO_LAST  = 1'b0,
    FLO_FIRST = 1'b1
  } flo_mode_e;

  // Widest index needed for W up to 4096; narrower users slice the low bits.
  localparam int                    FLO_IW_MAX = 13;
  localparam logic [FLO_IW_MAX-1:0] FLO_NONE   = '1;

  function automatic int flo_iw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/flo_seg.sv
// rtl/flo_seg.sv - combinational SEG-wide segment encoder (any, local index, popcount with FLO_POPCNT_EN)
module flo_seg
  import flo_pkg::*;
#(
  parameter int SEG = 32,
  parameter int LW  = $clog2(SEG)
) (
  input  logic [SEG-1:0] data_i,
  input  flo_mode_e      mode_i,
  output logic           any_o,
  output logic [LW-1:0]  idx_o
`ifdef FLO_POPCNT_EN
  ,
  output logic [LW:0]    cnt_o
`endif
);

  assign any_o = |data_i;

  // Later loop iterations win, so the scan order picks highest or lowest.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < SEG; i++) begin
      if (mode_i == FLO_LAST) begin
        if (data_i[i]) idx_o = LW'(i);
      end else begin
        if (data_i[SEG-1-i]) idx_o = LW'(SEG - 1 - i);
      end
    end
  end

`ifdef FLO_POPCNT_EN
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < SEG; i++) begin
      cnt_o = cnt_o + (LW+1)'(data_i[i]);
    end
  end
`endif

endmodule

// File: rtl/flo_pipe.sv
// rtl/flo_pipe.sv - two-stage pipelined find-last/first-one encoder with valid/ready and tag
// Optional population count output enabled by FLO_POPCNT_EN.
module flo_pipe
  import flo_pkg::*;
#(
  parameter int W    = 288,
  parameter int SEG  = 32,
  parameter int TAGW = 8,
  parameter int IW   = flo_iw(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_mode,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_idx,
  output logic            out_found,
  output logic [TAGW-1:0] out_tag
`ifdef FLO_POPCNT_EN
  ,
  output logic [IW-1:0]   out_cnt
`endif
);

  localparam int NSEG = (W + SEG - 1) / SEG;
  localparam int LW   = $clog2(SEG);
  localparam int PW   = NSEG * SEG;

  logic                       adv;
  logic [PW-1:0]              data_pad;
  logic [NSEG-1:0]            seg_any;
  logic [NSEG-1:0][LW-1:0]    seg_idx;

  logic                       s1_valid_q;
  flo_mode_e                  s1_mode_q;
  logic [TAGW-1:0]            s1_tag_q;
  logic [NSEG-1:0]            s1_any_q;
  logic [NSEG-1:0][LW-1:0]    s1_idx_q;

  logic [IW-1:0]              s2_idx_d;
  logic                       s2_found_d;
  logic                       out_valid_q;
  logic [IW-1:0]              out_idx_q;
  logic                       out_found_q;
  logic [TAGW-1:0]            out_tag_q;

`ifdef FLO_POPCNT_EN
  logic [NSEG-1:0][LW:0]      seg_cnt;
  logic [NSEG-1:0][LW:0]      s1_cnt_q;
  logic [IW-1:0]              s2_cnt_d;
  logic [IW-1:0]              out_cnt_q;
`endif

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    data_pad          = '0;
    data_pad[W-1:0]   = in_data;
  end

  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    flo_seg #(.SEG(SEG), .LW(LW)) u_seg (
      .data_i (data_pad[s*SEG +: SEG]),
      .mode_i (flo_mode_e'(in_mode)),
      .any_o  (seg_any[s]),
      .idx_o  (seg_idx[s])
`ifdef FLO_POPCNT_EN
      ,
      .cnt_o  (seg_cnt[s])
`endif
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= FLO_LAST;
      s1_tag_q   <= '0;
      s1_any_q   <= '0;
      s1_idx_q   <= '0;
`ifdef FLO_POPCNT_EN
      s1_cnt_q   <= '0;
`endif
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= flo_mode_e'(in_mode);
        s1_tag_q  <= in_tag;
        s1_any_q  <= seg_any;
        s1_idx_q  <= seg_idx;
`ifdef FLO_POPCNT_EN
        s1_cnt_q  <= seg_cnt;
`endif
      end
    end
  end

  // Segment select mirrors the bit scan: last flagged segment in scan order wins.
  always_comb begin
    int k;
    k          = 0;
    s2_idx_d   = FLO_NONE[IW-1:0];
    s2_found_d = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      k = (s1_mode_q == FLO_LAST) ? s : (NSEG - 1 - s);
      if (s1_any_q[k]) begin
        s2_found_d = 1'b1;
        s2_idx_d   = IW'(k * SEG) + IW'(s1_idx_q[k]);
      end
    end
  end

`ifdef FLO_POPCNT_EN
  always_comb begin
    s2_cnt_d = '0;
    for (int s = 0; s < NSEG; s++) begin
      s2_cnt_d = s2_cnt_d + IW'(s1_cnt_q[s]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= FLO_NONE[IW-1:0];
      out_found_q <= 1'b0;
      out_tag_q   <= '0;
`ifdef FLO_POPCNT_EN
      out_cnt_q   <= '0;
`endif
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_idx_q   <= s2_idx_d;
        out_found_q <= s2_found_d;
        out_tag_q   <= s1_tag_q;
`ifdef FLO_POPCNT_EN
        out_cnt_q   <= s2_cnt_d;
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_found = out_found_q;
  assign out_tag   = out_tag_q;
`ifdef FLO_POPCNT_EN
  assign out_cnt   = out_cnt_q;
`endif

endmodule
